// File: rtl/core_event_checker_if.sv
// Monitored core signals: cause-code event channels, one valid/ready handshake, retire strobe.
// The master drives these signals. The slave only observes them and gives no backpressure.
interface core_event_checker_if #(
  parameter int NCH    = 4,
  parameter int CODE_W = 32
);
  logic [NCH-1:0]        ev_valid;
  logic [NCH*CODE_W-1:0] ev_code;
  logic                  hs_valid;
  logic                  hs_ready;
  logic                  progress;

  modport master (output ev_valid, ev_code, hs_valid, hs_ready, progress);
  modport slave  (input  ev_valid, ev_code, hs_valid, hs_ready, progress);
endinterface

// File: rtl/core_event_checker.sv
// Event hit counters, handshake stall/withdraw checks and progress watchdog with sticky first-error capture.
// Outputs are registered and change one cycle after the condition. The block only observes, so it never applies backpressure.
module core_event_checker #(
  parameter int NCH    = 4,
  parameter int CODE_W = 32,
  parameter int CNT_W  = 16,
  parameter int TO_W   = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  core_event_checker_if.slave    mon,
  input  logic [15:0]            cfg_code_mask,
  input  logic [TO_W-1:0]        cfg_stall_limit,
  input  logic [TO_W-1:0]        cfg_timeout,
  input  logic                   clear,
  output logic [NCH*CNT_W-1:0]   hit_cnt,
  output logic                   err_sticky,
  output logic [2:0]             err_cause,
  output logic [3:0]             err_chan,
  output logic [CODE_W-1:0]      err_code,
  output logic                   fatal
);

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_EVENT = 3'd1,
    CAUSE_STALL = 3'd2,
    CAUSE_WDOG  = 3'd3,
    CAUSE_WDRAW = 3'd4
  } cause_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_MAX  = '1;

  logic [CNT_W-1:0]  hit_cnt_q [NCH];
  logic [CNT_W-1:0]  hit_cnt_d [NCH];
  logic [TO_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic              prev_stall_q, prev_stall_d;
  logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              err_sticky_q, err_sticky_d;
  cause_e            err_cause_q, err_cause_d;
  logic [3:0]        err_chan_q, err_chan_d;
  logic [CODE_W-1:0] err_code_q, err_code_d;
  logic              fatal_q, fatal_d;

  logic [CODE_W-1:0] code [NCH];
  logic [NCH-1:0]    hit;
  logic [3:0]        first_chan;
  logic [CODE_W-1:0] first_code;
  logic              stalled;
  logic              stall_err;
  logic              wdraw_err;
  logic              wd_err;
  cause_e            cause;

  // Codes of 16 or more never hit, so only the low nibble indexes the mask.
  always_comb begin
    hit        = '0;
    first_chan = '0;
    first_code = '0;
    for (int i = 0; i < NCH; i++) begin
      code[i] = mon.ev_code[i*CODE_W +: CODE_W];
      hit[i]  = mon.ev_valid[i] && ((code[i] >> 4) == '0) && cfg_code_mask[code[i][3:0]];
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_chan = 4'(i);
        first_code = code[i];
      end
    end
  end

  always_comb begin
    stalled   = mon.hs_valid && !mon.hs_ready;
    stall_err = stalled && (cfg_stall_limit != '0) && (stall_cnt_q == cfg_stall_limit);
    wdraw_err = prev_stall_q && !mon.hs_valid;
    wd_err    = !mon.progress && (cfg_timeout != '0) && (wd_cnt_q == cfg_timeout);

    cause = CAUSE_NONE;
    if (wd_err)         cause = CAUSE_WDOG;
    else if (stall_err) cause = CAUSE_STALL;
    else if (wdraw_err) cause = CAUSE_WDRAW;
    else if (|hit)      cause = CAUSE_EVENT;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit_cnt_d[i] = hit_cnt_q[i];
      if (hit[i] && hit_cnt_q[i] != CNT_MAX) hit_cnt_d[i] = hit_cnt_q[i] + 1'b1;
    end

    stall_cnt_d  = '0;
    if (stalled) stall_cnt_d = (stall_cnt_q == TO_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
    prev_stall_d = stalled;

    wd_cnt_d = '0;
    if (!mon.progress) wd_cnt_d = (wd_cnt_q == TO_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;

    err_sticky_d = err_sticky_q;
    err_cause_d  = err_cause_q;
    err_chan_d   = err_chan_q;
    err_code_d   = err_code_q;
    fatal_d      = 1'b0;
    if (!err_sticky_q && cause != CAUSE_NONE) begin
      err_sticky_d = 1'b1;
      err_cause_d  = cause;
      err_chan_d   = (cause == CAUSE_EVENT) ? first_chan : 4'd0;
      err_code_d   = (cause == CAUSE_EVENT) ? first_code : '0;
      fatal_d      = 1'b1;
    end

    // Clear discards everything observed in its own cycle.
    if (clear) begin
      for (int i = 0; i < NCH; i++) hit_cnt_d[i] = '0;
      stall_cnt_d  = '0;
      prev_stall_d = 1'b0;
      wd_cnt_d     = '0;
      err_sticky_d = 1'b0;
      err_cause_d  = CAUSE_NONE;
      err_chan_d   = '0;
      err_code_d   = '0;
      fatal_d      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) hit_cnt_q[i] <= '0;
      stall_cnt_q  <= '0;
      prev_stall_q <= 1'b0;
      wd_cnt_q     <= '0;
      err_sticky_q <= 1'b0;
      err_cause_q  <= CAUSE_NONE;
      err_chan_q   <= '0;
      err_code_q   <= '0;
      fatal_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) hit_cnt_q[i] <= hit_cnt_d[i];
      stall_cnt_q  <= stall_cnt_d;
      prev_stall_q <= prev_stall_d;
      wd_cnt_q     <= wd_cnt_d;
      err_sticky_q <= err_sticky_d;
      err_cause_q  <= err_cause_d;
      err_chan_q   <= err_chan_d;
      err_code_q   <= err_code_d;
      fatal_q      <= fatal_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
    assign hit_cnt[g*CNT_W +: CNT_W] = hit_cnt_q[g];
  end

  assign err_sticky = err_sticky_q;
  assign err_cause  = err_cause_q;
  assign err_chan   = err_chan_q;
  assign err_code   = err_code_q;
  assign fatal      = fatal_q;

endmodule
